srl_chain_test_ctrl: RTL and testbench

//  Drives and checks NUM_CHAINS cascaded SRL16 shift-register chains in the SRL hardware tests.
//  One LFSR supplies a distinct pseudo-random bit to each chain.
//  A second, delayed LFSR predicts each chain output. Mismatches latch into sticky per-chain

---
 rtl/srl_chain_pkg.sv | 17 +
 rtl/srl_lfsr16.sv | 24 ++
 rtl/srl_chain_test_ctrl.sv | 135 +++++++++++++
 tb/tb_srl_chain_test_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/srl_chain_pkg.sv
// rtl/srl_chain_pkg.sv - shared LFSR definitions and FSM state type for the SRL chain tester
package srl_chain_pkg;

    localparam int LFSR_W = 16;
    // x^16 + x^14 + x^13 + x^11 + 1 expressed as state bit positions 15, 13, 12, 10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/srl_lfsr16.sv
// rtl/srl_lfsr16.sv - seeded 16-bit Fibonacci LFSR with advance enable and reseed load
module srl_lfsr16
    import srl_chain_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (load) begin
            state <= SEED;
        end else if (en) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/srl_chain_test_ctrl.sv
// rtl/srl_chain_test_ctrl.sv - drives NUM_CHAINS SRL chains from one LFSR and checks them against a delayed copy
module srl_chain_test_ctrl
    import srl_chain_pkg::*;
#(
    parameter int          NUM_CHAINS  = 8,
    parameter int          CHAIN_DEPTH = 64,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  restart,
    input  logic                  clear,
    input  logic [3:0]            throttle,
    input  logic [NUM_CHAINS-1:0] chain_q,
    output logic [NUM_CHAINS-1:0] chain_d,
    output logic                  chain_ce,
    output logic [NUM_CHAINS-1:0] error,
    output logic [15:0]           err_cnt,
    output logic                  running
);

    localparam int                FILL_W    = $clog2(CHAIN_DEPTH + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(CHAIN_DEPTH - 1);

    if (SEED == 16'h0000) begin : g_seed_check
        $error("srl_chain_test_ctrl: SEED must be nonzero");
    end

    state_t              state_q, state_d;
    logic [FILL_W-1:0]   fill_cnt, fill_cnt_d;
    logic [3:0]          div_cnt, div_limit, div_next, thr_lat;
    logic                ce_d1;
    logic                compare;
    logic [NUM_CHAINS-1:0] mismatch;
    logic [LFSR_W-1:0]   gen, exp_state;
    logic                unused_hi;

    // A new throttle value is only picked up at the start of a period (div_cnt == 0).
    assign div_limit = (div_cnt == 4'd0) ? throttle : thr_lat;
    assign div_next  = (div_cnt >= div_limit) ? 4'd0 : div_cnt + 4'd1;

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt;
        compare    = 1'b0;
        if (restart) begin
            state_d    = FILL;
            fill_cnt_d = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (chain_ce) begin
                        if (fill_cnt == FILL_LAST) begin
                            state_d    = RUN;
                            fill_cnt_d = '0;
                        end else begin
                            fill_cnt_d = fill_cnt + 1'b1;
                        end
                    end
                end
                RUN:     compare = ce_d1;
                default: state_d = FILL;
            endcase
        end
    end

    always_comb begin
        mismatch = '0;
        if (compare) begin
            mismatch = chain_q ^ exp_state[NUM_CHAINS-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            fill_cnt <= '0;
            div_cnt  <= 4'd0;
            thr_lat  <= 4'd0;
            chain_ce <= 1'b0;
            ce_d1    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_cnt <= fill_cnt_d;
            if (restart) begin
                div_cnt  <= 4'd0;
                thr_lat  <= 4'd0;
                chain_ce <= 1'b0;
                ce_d1    <= 1'b0;
            end else begin
                div_cnt  <= div_next;
                thr_lat  <= div_limit;
                chain_ce <= (div_next == 4'd0);
                ce_d1    <= chain_ce;
            end
        end
    end

    // Clear has priority over a mismatch arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error   <= '0;
            err_cnt <= 16'h0000;
        end else if (clear) begin
            error   <= '0;
            err_cnt <= 16'h0000;
        end else if (|mismatch) begin
            error <= error | mismatch;
            if (err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'h0001;
            end
        end
    end

    srl_lfsr16 #(.SEED(SEED)) u_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (chain_ce),
        .load  (restart),
        .state (gen)
    );

    srl_lfsr16 #(.SEED(SEED)) u_exp (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (compare),
        .load  (restart),
        .state (exp_state)
    );

    assign chain_d   = gen[NUM_CHAINS-1:0];
    assign running   = (state_q == RUN);
    assign unused_hi = ^{gen, exp_state};

endmodule

// File: tb/tb_srl_chain_test_ctrl.sv
// tb/tb_srl_chain_test_ctrl.sv - randomized scoreboard bench for srl_chain_test_ctrl with an external SRL chain model
module tb_srl_chain_test_ctrl;

    localparam int          N    = 8;
    localparam int          D    = 64;
    localparam logic [15:0] SEED = 16'hACE1;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         restart  = 1'b0;
    logic         clear    = 1'b0;
    logic [3:0]   throttle = 4'd0;
    logic [N-1:0] chain_q;
    logic [N-1:0] chain_d;
    logic         chain_ce;
    logic [N-1:0] error;
    logic [15:0]  err_cnt;
    logic         running;

    always #5 clk = ~clk;

    srl_chain_test_ctrl #(.NUM_CHAINS(N), .CHAIN_DEPTH(D), .SEED(SEED)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (restart),
        .clear    (clear),
        .throttle (throttle),
        .chain_q  (chain_q),
        .chain_d  (chain_d),
        .chain_ce (chain_ce),
        .error    (error),
        .err_cnt  (err_cnt),
        .running  (running)
    );

    // External chains: D-deep (or D-1 when short_chain), flushed alongside restart.
    logic [N-1:0] sr [D];
    logic         short_chain = 1'b0;
    logic [N-1:0] inv = '0;

    always @(posedge clk) begin
        if (restart) begin
            for (int j = 0; j < D; j++) sr[j] <= '0;
        end else if (chain_ce) begin
            sr[0] <= chain_d;
            for (int j = 1; j < D; j++) sr[j] <= sr[j-1];
        end
    end

    assign chain_q = (short_chain ? sr[D-2] : sr[D-1]) ^ inv;

    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    typedef struct packed {
        logic         ce;
        logic [N-1:0] d;
        logic         run;
        logic [N-1:0] err;
        logic [15:0]  cnt;
    } obs_t;

    obs_t exp_q[$];

    // Reference model: t_m counts cycles since reset/restart; chain_ce every (thr+1) cycles,
    // D-th shift enters RUN, compares occur on the cycle after each shift.
    int           t_m;
    int           thr_m;
    logic [15:0]  g_m, e_m, cnt_m;
    logic [N-1:0] err_m, mism_m;
    logic         cmp_m;
    obs_t         o_m;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_m = 0; thr_m = 0; g_m = SEED; e_m = SEED; err_m = '0; cnt_m = '0;
            o_m.ce = 1'b0; o_m.d = g_m[N-1:0]; o_m.run = 1'b0; o_m.err = '0; o_m.cnt = '0;
            exp_q.push_back(o_m);
        end else begin
            if (t_m == 0) thr_m = int'(throttle);
            o_m.ce  = (t_m > 0) && (t_m % (thr_m + 1) == 0);
            o_m.d   = g_m[N-1:0];
            o_m.run = (t_m > D * (thr_m + 1));
            o_m.err = err_m;
            o_m.cnt = cnt_m;
            exp_q.push_back(o_m);
            cmp_m  = o_m.run && ((t_m - 1) % (thr_m + 1) == 0) && !restart;
            mism_m = cmp_m ? (chain_q ^ e_m[N-1:0]) : '0;
            if (cmp_m) e_m = step(e_m);
            if (o_m.ce) g_m = step(g_m);
            if (clear) begin
                err_m = '0; cnt_m = '0;
            end else if (mism_m != '0) begin
                err_m = err_m | mism_m;
                if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
            end
            if (restart) begin
                t_m = 0; g_m = SEED; e_m = SEED;
            end else begin
                t_m = t_m + 1;
            end
        end
    end

    int   n_checks = 0;
    int   n_errors = 0;
    obs_t e_o, g_o;

    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL scoreboard_empty at %0t: got no expectation, required one", $time);
            end else begin
                e_o = exp_q.pop_front();
                g_o.ce = chain_ce; g_o.d = chain_d; g_o.run = running; g_o.err = error; g_o.cnt = err_cnt;
                if (g_o !== e_o) begin
                    n_errors++;
                    $display("FAIL outputs at %0t: got ce=%b d=%h run=%b err=%h cnt=%0d required ce=%b d=%h run=%b err=%h cnt=%0d",
                             $time, g_o.ce, g_o.d, g_o.run, g_o.err, g_o.cnt,
                             e_o.ce, e_o.d, e_o.run, e_o.err, e_o.cnt);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int b1, b2;

    initial begin
        tick(3);
        rst_n = 1'b1;

        // Ideal chains, throttle 0
        tick(10000);
        check("t1_error", 32'(error), 32'd0);
        check("t1_err_cnt", 32'(err_cnt), 32'd0);
        check("t1_running", 32'(running), 32'd1);

        // One inverted compare on a random chain
        b1 = $urandom_range(0, N - 1);
        inv = N'(1) << b1;
        tick(1);
        inv = '0;
        tick(20);
        check("t2_error", 32'(error), 32'(N'(1) << b1));
        check("t2_err_cnt", 32'(err_cnt), 32'd1);

        // throttle 3
        throttle = 4'd3;
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check("t3_running_after_restart", 32'(running), 32'd0);
        tick(4 * D + 40);
        check("t3_running", 32'(running), 32'd1);
        check("t3_error_kept", 32'(error), 32'(N'(1) << b1));

        // Short chain, restart and clear together
        throttle = 4'd0;
        short_chain = 1'b1;
        restart = 1'b1;
        clear = 1'b1;
        tick(1);
        restart = 1'b0;
        clear = 1'b0;
        check("t4_error_cleared", 32'(error), 32'd0);
        check("t4_cnt_cleared", 32'(err_cnt), 32'd0);
        tick(D + 1 + 40);
        check("t4_all_flag", 32'(error), 32'hFF);
        check("t4_cnt_nonzero", 32'(err_cnt != 16'd0), 32'd1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("t4_clear_error", 32'(error), 32'd0);
        check("t4_clear_cnt", 32'(err_cnt), 32'd0);
        tick(40);
        check("t4_reflag", 32'(error != '0), 32'd1);

        // Async reset mid-RUN
        short_chain = 1'b0;
        restart = 1'b1;
        clear = 1'b1;
        tick(1);
        restart = 1'b0;
        clear = 1'b0;
        tick(D + 20);
        rst_n = 1'b0;
        #1;
        check("t5_async_running", 32'(running), 32'd0);
        check("t5_async_ce", 32'(chain_ce), 32'd0);
        #2;
        rst_n = 1'b1;
        tick(D + 100);
        check("t5_error", 32'(error), 32'd0);
        check("t5_err_cnt", 32'(err_cnt), 32'd0);
        check("t5_running", 32'(running), 32'd1);

        // Restart mid-RUN with chains flushed
        b2 = $urandom_range(0, N - 1);
        inv = N'(1) << b2;
        tick(1);
        inv = '0;
        tick(5);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(D);
        check("t6_running_low", 32'(running), 32'd0);
        tick(1);
        check("t6_running_high", 32'(running), 32'd1);
        tick(50);
        check("t6_error_kept", 32'(error), 32'(N'(1) << b2));
        check("t6_err_cnt", 32'(err_cnt), 32'd1);

        // Random clears, faults, restarts and throttles
        for (int i = 0; i < 3000; i++) begin
            clear = ($urandom_range(0, 49) == 0);
            inv = ($urandom_range(0, 39) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 499) == 0) begin
                restart = 1'b1;
                throttle = 4'($urandom_range(0, 4));
            end else begin
                restart = 1'b0;
            end
            tick(1);
        end
        clear = 1'b0;
        inv = '0;
        restart = 1'b0;
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
